// File: rtl/cordic_seq_ctrl.sv
// Iterative rotation-mode CORDIC: one registered shift cycle and one add/sub cycle per iteration.
// Optional abort input is compiled in when CORDIC_SEQ_ABORT_EN is defined.
module cordic_seq_ctrl #(
    parameter int ITER = 13,
    parameter int IW   = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef CORDIC_SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic signed [15:0] angle,
    output logic               busy,
    output logic               done,
    output logic signed [15:0] sin_out,
    output logic signed [15:0] cos_out,
    output logic [3:0]         iter_idx
);

    localparam int                   ZW       = 17;
    localparam logic signed [IW-1:0] K_INIT   = IW'(9949);
    localparam logic signed [IW-1:0] SAT_MAX  = IW'(32767);
    localparam logic signed [IW-1:0] SAT_MIN  = IW'(-32768);
    localparam logic signed [15:0]   ANG_MAX  = 16'sd25736;
    localparam logic signed [15:0]   ANG_MIN  = -16'sd25736;
    localparam logic [3:0]           LAST_IDX = 4'(ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_ROTATE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic signed [IW-1:0] x_q, x_d, y_q, y_d;
    logic signed [IW-1:0] xs_q, xs_d, ys_q, ys_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic [3:0]           i_q, i_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic signed [15:0]   sin_q, sin_d, cos_q, cos_d;

    function automatic logic signed [15:0] sat16(input logic signed [IW-1:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7fff;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end
        return v[15:0];
    endfunction

    // Limit to +/-pi/2 so the rotation stays within CORDIC convergence.
    function automatic logic signed [ZW-1:0] clamp_angle(input logic signed [15:0] a);
        logic signed [15:0] c;
        if (a > ANG_MAX) begin
            c = ANG_MAX;
        end else if (a < ANG_MIN) begin
            c = ANG_MIN;
        end else begin
            c = a;
        end
        return {c[15], c};
    endfunction

    function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 17'sd12868;
            4'd1:    return 17'sd7596;
            4'd2:    return 17'sd4014;
            4'd3:    return 17'sd2037;
            4'd4:    return 17'sd1023;
            4'd5:    return 17'sd512;
            4'd6:    return 17'sd256;
            4'd7:    return 17'sd128;
            4'd8:    return 17'sd64;
            4'd9:    return 17'sd32;
            4'd10:   return 17'sd16;
            4'd11:   return 17'sd8;
            4'd12:   return 17'sd4;
            default: return 17'sd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        i_d     = i_q;
        done_d  = 1'b0;
        sin_d   = sin_q;
        cos_d   = cos_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                z_d     = clamp_angle(angle);
                x_d     = K_INIT;
                y_d     = '0;
                i_d     = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                xs_d    = x_q >>> i_q;
                ys_d    = y_q >>> i_q;
                state_d = S_ROTATE;
            end
            S_ROTATE: begin
                // A zero residual angle rotates in the positive direction.
                if (!z_q[ZW-1]) begin
                    x_d = x_q - ys_q;
                    y_d = y_q + xs_q;
                    z_d = z_q - atan_lut(i_q);
                end else begin
                    x_d = x_q + ys_q;
                    y_d = y_q - xs_q;
                    z_d = z_q + atan_lut(i_q);
                end
                if (i_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 4'd1;
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                sin_d   = sat16(y_q);
                cos_d   = sat16(x_q);
                done_d  = 1'b1;
                i_d     = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef CORDIC_SEQ_ABORT_EN
        // Abort beats start in IDLE and drops any computation that has not reached DONE.
        if (abort && (state_q != S_DONE)) begin
            state_d = S_IDLE;
            i_d     = '0;
        end
`endif
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sin_out  = sin_q;
    assign cos_out  = cos_q;
    assign iter_idx = i_q;

endmodule
